// File: rtl/xadac_pkg.sv
// Shared types and helpers for the xadac accelerator link.
// Covers the custom-0 opcode, the funct3 codes, and the decode and execute payloads.
package xadac_pkg;

   localparam int XLEN = 32;
   localparam int ID_W = 4;

   localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

   typedef enum logic [2:0] {
      F3_ADD = 3'b000,
      F3_SUB = 3'b001,
      F3_XOR = 3'b100,
      F3_AND = 3'b111
   } xadac_f3_e;

   typedef logic [ID_W-1:0] xadac_id_t;

   typedef struct packed {
      xadac_id_t   id;
      logic [31:0] instr;
   } dec_req_t;

   typedef struct packed {
      xadac_id_t id;
      logic      accept;
   } dec_rsp_t;

   typedef struct packed {
      xadac_id_t       id;
      logic [31:0]     instr;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
   } exe_req_t;

   typedef struct packed {
      xadac_id_t       id;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } exe_rsp_t;

   // Only custom-0 with one of the four implemented funct3 codes is accepted.
   function automatic logic dec_accepts(input logic [6:0] opc, input logic [2:0] f3);
      logic f3_ok;
      case (f3)
         F3_ADD, F3_SUB, F3_XOR, F3_AND: f3_ok = 1'b1;
         default:                        f3_ok = 1'b0;
      endcase
      return (opc == OPC_CUSTOM0) && f3_ok;
   endfunction

   function automatic logic [XLEN-1:0] xadac_alu(input logic [2:0]      f3,
                                                input logic [XLEN-1:0] rs1,
                                                input logic [XLEN-1:0] rs2);
      logic [XLEN-1:0] res;
      case (f3)
         F3_ADD:  res = rs1 + rs2;
         F3_SUB:  res = rs1 - rs2;
         F3_XOR:  res = rs1 ^ rs2;
         F3_AND:  res = rs1 & rs2;
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/xadac_resp_fifo.sv
// Circular response buffer. The head entry drives the execute response directly.
// Capacity is guaranteed by the caller's credit scheme.
module xadac_resp_fifo #(
   parameter type data_t = logic [7:0],
   parameter int  DEPTH  = 4
) (
   input  logic  clk,
   input  logic  rstn,
   input  logic  push,
   input  data_t push_data,
   input  logic  pop,
   output logic  full,
   output logic  empty,
   output data_t head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   data_t         mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // NOTE: this buffer is a handful of flops, so it is reset; the head payload then reads zero out of reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/xadac_resp_unit.sv
// Responder endpoint of the xadac link. Decode gets a one-cycle accept/reject.
// Execute runs a fixed-latency pipeline into an in-order, credit-managed response buffer.
module xadac_resp_unit
   import xadac_pkg::*;
#(
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4
) (
   input  logic            clk,
   input  logic            rstn,
   // decode request / response
   input  logic [ID_W-1:0] dec_req_id,
   input  logic [31:0]     dec_req_instr,
   input  logic            dec_req_valid,
   output logic            dec_req_ready,
   output logic [ID_W-1:0] dec_rsp_id,
   output logic            dec_rsp_accept,
   output logic            dec_rsp_valid,
   input  logic            dec_rsp_ready,
   // execute request / response
   input  logic [ID_W-1:0] exe_req_id,
   input  logic [31:0]     exe_req_instr,
   input  logic [XLEN-1:0] exe_req_rs1,
   input  logic [XLEN-1:0] exe_req_rs2,
   input  logic            exe_req_valid,
   output logic            exe_req_ready,
   output logic [ID_W-1:0] exe_rsp_id,
   output logic [4:0]      exe_rsp_rd,
   output logic [XLEN-1:0] exe_rsp_data,
   output logic            exe_rsp_valid,
   input  logic            exe_rsp_ready
);

   localparam int OW = $clog2(DEPTH + 1);

   // ---------------------------------------------------------------- decode
   logic dec_req_fire;

   assign dec_req_ready = !dec_rsp_valid || dec_rsp_ready;
   assign dec_req_fire  = dec_req_valid && dec_req_ready;

   // A new request landing while the old response drains overwrites it and keeps valid high.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dec_rsp_valid  <= 1'b0;
         dec_rsp_id     <= '0;
         dec_rsp_accept <= 1'b0;
      end else if (dec_req_fire) begin
         dec_rsp_valid  <= 1'b1;
         dec_rsp_id     <= dec_req_id;
         dec_rsp_accept <= dec_accepts(dec_req_instr[6:0], dec_req_instr[14:12]);
      end else if (dec_rsp_ready) begin
         dec_rsp_valid  <= 1'b0;
      end
   end

   // --------------------------------------------------------------- execute
   logic          exe_req_fire;
   logic          exe_rsp_fire;
   logic [OW-1:0] outstanding;

   // Credits come from registered state only, so a pop frees a slot one cycle later.
   assign exe_req_ready = (outstanding < OW'(DEPTH));
   assign exe_req_fire  = exe_req_valid && exe_req_ready;
   assign exe_rsp_fire  = exe_rsp_valid && exe_rsp_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         outstanding <= '0;
      end else begin
         case ({exe_req_fire, exe_rsp_fire})
            2'b10:   outstanding <= outstanding + OW'(1);
            2'b01:   outstanding <= outstanding - OW'(1);
            default: ;
         endcase
      end
   end

   logic [LATENCY-1:0] stg_vld;
   exe_rsp_t           stg_dat [LATENCY];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stg_vld <= '0;
      end else begin
         stg_vld[0] <= exe_req_fire;
         for (int i = 1; i < LATENCY; i++) begin
            stg_vld[i] <= stg_vld[i-1];
         end
      end
   end

   // NOTE: pipeline payload has no reset; stg_vld alone decides whether a stage holds a live op.
   always_ff @(posedge clk) begin
      stg_dat[0] <= '{id:   exe_req_id,
                      rd:   exe_req_instr[11:7],
                      data: xadac_alu(exe_req_instr[14:12], exe_req_rs1, exe_req_rs2)};
      for (int i = 1; i < LATENCY; i++) begin
         stg_dat[i] <= stg_dat[i-1];
      end
   end

   // --------------------------------------------------------- response buffer
   exe_rsp_t fifo_head;
   logic     fifo_full;
   logic     fifo_empty;

   xadac_resp_fifo #(
      .data_t (exe_rsp_t),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (stg_vld[LATENCY-1]),
      .push_data (stg_dat[LATENCY-1]),
      .pop       (exe_rsp_fire),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   assign exe_rsp_valid = !fifo_empty;
   assign exe_rsp_id    = fifo_head.id;
   assign exe_rsp_rd    = fifo_head.rd;
   assign exe_rsp_data  = fifo_head.data;

   // The credit counter must make a push into a full buffer impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
                                   !(stg_vld[LATENCY-1] && fifo_full));

   // Instruction fields this unit does not interpret.
   logic unused_ok;
   assign unused_ok = ^{dec_req_instr[31:15], dec_req_instr[11:7],
                        exe_req_instr[31:15], exe_req_instr[6:0], fifo_full};

endmodule

// File: tb/tb_xadac_resp_unit.sv
// Directed bench for xadac_resp_unit (LATENCY=2, DEPTH=4).
// Expected values are hand-computed in the stimulus.
module tb_xadac_resp_unit;
   import xadac_pkg::*;

   logic            clk = 1'b0;
   logic            rstn;
   logic [ID_W-1:0] dec_req_id;
   logic [31:0]     dec_req_instr;
   logic            dec_req_valid;
   logic            dec_req_ready;
   logic [ID_W-1:0] dec_rsp_id;
   logic            dec_rsp_accept;
   logic            dec_rsp_valid;
   logic            dec_rsp_ready;
   logic [ID_W-1:0] exe_req_id;
   logic [31:0]     exe_req_instr;
   logic [XLEN-1:0] exe_req_rs1;
   logic [XLEN-1:0] exe_req_rs2;
   logic            exe_req_valid;
   logic            exe_req_ready;
   logic [ID_W-1:0] exe_rsp_id;
   logic [4:0]      exe_rsp_rd;
   logic [XLEN-1:0] exe_rsp_data;
   logic            exe_rsp_valid;
   logic            exe_rsp_ready;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   xadac_resp_unit #(
      .LATENCY (2),
      .DEPTH   (4)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .dec_req_id     (dec_req_id),
      .dec_req_instr  (dec_req_instr),
      .dec_req_valid  (dec_req_valid),
      .dec_req_ready  (dec_req_ready),
      .dec_rsp_id     (dec_rsp_id),
      .dec_rsp_accept (dec_rsp_accept),
      .dec_rsp_valid  (dec_rsp_valid),
      .dec_rsp_ready  (dec_rsp_ready),
      .exe_req_id     (exe_req_id),
      .exe_req_instr  (exe_req_instr),
      .exe_req_rs1    (exe_req_rs1),
      .exe_req_rs2    (exe_req_rs2),
      .exe_req_valid  (exe_req_valid),
      .exe_req_ready  (exe_req_ready),
      .exe_rsp_id     (exe_rsp_id),
      .exe_rsp_rd     (exe_rsp_rd),
      .exe_rsp_data   (exe_rsp_data),
      .exe_rsp_valid  (exe_rsp_valid),
      .exe_rsp_ready  (exe_rsp_ready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd,
                                            input logic [6:0] opc);
      return {17'd0, f3, rd, opc};
   endfunction

   // One execute op with an idle buffer: result must appear exactly two edges after acceptance.
   task automatic exe_single(input string tag, input logic [3:0] id, input logic [2:0] f3,
                             input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
      exe_req_valid = 1'b1;
      exe_req_id    = id;
      exe_req_instr = mk_instr(f3, rd, OPC_CUSTOM0);
      exe_req_rs1   = a;
      exe_req_rs2   = b;
      #1 check({tag, " req_ready"}, 64'(exe_req_ready), 64'd1);
      step();
      exe_req_valid = 1'b0;
      check({tag, " valid_e0"}, 64'(exe_rsp_valid), 64'd0);
      step();
      check({tag, " valid_e1"}, 64'(exe_rsp_valid), 64'd0);
      step();
      check({tag, " valid_e2"}, 64'(exe_rsp_valid), 64'd1);
      check({tag, " id"},       64'(exe_rsp_id),    64'(id));
      check({tag, " rd"},       64'(exe_rsp_rd),    64'(rd));
      check({tag, " data"},     64'(exe_rsp_data),  64'(exp));
      step();
      check({tag, " drained"},  64'(exe_rsp_valid), 64'd0);
   endtask

   // Back-to-back decode table: opcode, funct3, expected accept.
   logic [6:0] dec_opc [6] = '{7'b0001011, 7'b0001011, 7'b0001011, 7'b0001011, 7'b0001011, 7'b0110011};
   logic [2:0] dec_f3  [6] = '{3'b000,     3'b001,     3'b100,     3'b111,     3'b010,     3'b000};
   logic       dec_acc [6] = '{1'b1,       1'b1,       1'b1,       1'b1,       1'b0,       1'b0};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int got;
      int stale;
      bit first;

      rstn          = 1'b0;
      dec_req_id    = '0;
      dec_req_instr = '0;
      dec_req_valid = 1'b0;
      dec_rsp_ready = 1'b0;
      exe_req_id    = '0;
      exe_req_instr = '0;
      exe_req_rs1   = '0;
      exe_req_rs2   = '0;
      exe_req_valid = 1'b0;
      exe_rsp_ready = 1'b0;

      // reset state
      #12;
      check("rst dec_rsp_valid", 64'(dec_rsp_valid), 64'd0);
      check("rst exe_rsp_valid", 64'(exe_rsp_valid), 64'd0);
      check("rst exe_req_ready", 64'(exe_req_ready), 64'd1);
      check("rst dec_rsp_id",    64'(dec_rsp_id),    64'd0);
      check("rst exe_rsp_data",  64'(exe_rsp_data),  64'd0);
      rstn = 1'b1;
      step();

      // decode accept, latency 1
      dec_rsp_ready = 1'b1;
      dec_req_valid = 1'b1;
      dec_req_id    = 4'd3;
      dec_req_instr = mk_instr(3'b000, 5'd1, 7'b0001011);
      #1 check("dec_acc ready", 64'(dec_req_ready), 64'd1);
      step();
      dec_req_valid = 1'b0;
      check("dec_acc valid",  64'(dec_rsp_valid),  64'd1);
      check("dec_acc id",     64'(dec_rsp_id),     64'd3);
      check("dec_acc accept", 64'(dec_rsp_accept), 64'd1);
      #1 check("dec_acc ready_after", 64'(dec_req_ready), 64'd1);
      step();
      check("dec_acc drained", 64'(dec_rsp_valid), 64'd0);

      // decode reject with response stall
      dec_rsp_ready = 1'b0;
      dec_req_valid = 1'b1;
      dec_req_id    = 4'd5;
      dec_req_instr = mk_instr(3'b000, 5'd1, 7'b0110011);
      step();
      dec_req_valid = 1'b0;
      check("dec_rej valid",  64'(dec_rsp_valid),  64'd1);
      check("dec_rej id",     64'(dec_rsp_id),     64'd5);
      check("dec_rej accept", 64'(dec_rsp_accept), 64'd0);
      #1 check("dec_rej stall_ready", 64'(dec_req_ready), 64'd0);
      step();
      check("dec_rej hold_valid", 64'(dec_rsp_valid),  64'd1);
      check("dec_rej hold_id",    64'(dec_rsp_id),     64'd5);
      check("dec_rej hold_acc",   64'(dec_rsp_accept), 64'd0);
      dec_rsp_ready = 1'b1;
      #1 check("dec_rej ready_on_drain", 64'(dec_req_ready), 64'd1);
      step();
      check("dec_rej drained", 64'(dec_rsp_valid), 64'd0);

      // back-to-back decode at full rate
      for (int i = 0; i < 6; i++) begin
         dec_req_valid = 1'b1;
         dec_req_id    = 4'(8 + i);
         dec_req_instr = mk_instr(dec_f3[i], 5'd2, dec_opc[i]);
         #1 check("dec_b2b ready", 64'(dec_req_ready), 64'd1);
         step();
         check("dec_b2b valid",  64'(dec_rsp_valid),  64'd1);
         check("dec_b2b id",     64'(dec_rsp_id),     64'(8 + i));
         check("dec_b2b accept", 64'(dec_rsp_accept), 64'(dec_acc[i]));
      end
      dec_req_valid = 1'b0;
      step();
      check("dec_b2b drained", 64'(dec_rsp_valid), 64'd0);

      // single execute ops
      exe_rsp_ready = 1'b1;
      exe_single("exe_add", 4'd1, F3_ADD, 5'd10, 32'd5,          32'd7,          32'd12);
      exe_single("exe_sub", 4'd2, F3_SUB, 5'd3,  32'd0,          32'd1,          32'hFFFF_FFFF);
      exe_single("exe_xor", 4'd3, F3_XOR, 5'd4,  32'hF0F0_0000,  32'h0FF0_00FF,  32'hFF00_00FF);
      exe_single("exe_and", 4'd4, F3_AND, 5'd5,  32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234);
      exe_single("exe_bad", 4'd6, 3'b010, 5'd6,  32'h1234_5678,  32'h1111_1111,  32'd0);

      // back-pressure: only DEPTH ops accepted while responses are blocked
      exe_rsp_ready = 1'b0;
      sent = 0;
      for (int c = 0; c < 8; c++) begin
         exe_req_valid = (sent < 6);
         exe_req_id    = 4'(sent);
         exe_req_instr = mk_instr(F3_ADD, 5'(sent + 1), OPC_CUSTOM0);
         exe_req_rs1   = 32'(sent * 10);
         exe_req_rs2   = 32'(sent);
         #1;
         if (exe_req_valid && exe_req_ready) sent++;
         step();
      end
      check("bp accepted",  64'(sent),          64'd4);
      check("bp req_ready", 64'(exe_req_ready), 64'd0);
      check("bp rsp_valid", 64'(exe_rsp_valid), 64'd1);
      check("bp head_id",   64'(exe_rsp_id),    64'd0);

      // release: responses in order, a credit returns only one cycle after each pop
      exe_rsp_ready = 1'b1;
      got   = 0;
      first = 1'b1;
      for (int c = 0; c < 40 && got < 6; c++) begin
         exe_req_valid = (sent < 6);
         exe_req_id    = 4'(sent);
         exe_req_instr = mk_instr(F3_ADD, 5'(sent + 1), OPC_CUSTOM0);
         exe_req_rs1   = 32'(sent * 10);
         exe_req_rs2   = 32'(sent);
         #1;
         if (exe_rsp_valid) begin
            check("bp order_id", 64'(exe_rsp_id),   64'(got));
            check("bp rd",       64'(exe_rsp_rd),   64'(got + 1));
            check("bp data",     64'(exe_rsp_data), 64'(got * 11));
            if (first) begin
               check("bp no_passthrough", 64'(exe_req_ready), 64'd0);
               first = 1'b0;
            end
            got++;
         end
         if (exe_req_valid && exe_req_ready) sent++;
         step();
      end
      exe_req_valid = 1'b0;
      check("bp returned", 64'(got),  64'd6);
      check("bp sent",     64'(sent), 64'd6);
      check("bp empty",    64'(exe_rsp_valid), 64'd0);
      check("bp ready",    64'(exe_req_ready), 64'd1);

      // reset with three ops in flight and a decode response pending
      exe_rsp_ready = 1'b0;
      dec_rsp_ready = 1'b0;
      dec_req_valid = 1'b1;
      dec_req_id    = 4'd6;
      dec_req_instr = mk_instr(3'b000, 5'd1, 7'b0001011);
      for (int i = 0; i < 3; i++) begin
         exe_req_valid = 1'b1;
         exe_req_id    = 4'(7 + i);
         exe_req_instr = mk_instr(F3_ADD, 5'd9, OPC_CUSTOM0);
         exe_req_rs1   = 32'd1;
         exe_req_rs2   = 32'd1;
         step();
      end
      dec_req_valid = 1'b0;
      exe_req_valid = 1'b0;
      step();
      check("mid pre_exe_valid", 64'(exe_rsp_valid), 64'd1);
      check("mid pre_dec_valid", 64'(dec_rsp_valid), 64'd1);
      #3 rstn = 1'b0;
      #1;
      check("mid async_exe_valid", 64'(exe_rsp_valid), 64'd0);
      check("mid async_dec_valid", 64'(dec_rsp_valid), 64'd0);
      check("mid async_req_ready", 64'(exe_req_ready), 64'd1);
      check("mid async_rsp_id",    64'(exe_rsp_id),    64'd0);
      step();
      step();
      #2 rstn = 1'b1;
      exe_rsp_ready = 1'b1;
      dec_rsp_ready = 1'b1;
      stale = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (exe_rsp_valid || dec_rsp_valid) stale++;
      end
      check("mid no_stale",  64'(stale),         64'd0);
      check("mid req_ready", 64'(exe_req_ready), 64'd1);
      exe_single("post_rst", 4'd11, F3_ADD, 5'd7, 32'd100, 32'd23, 32'd123);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
